// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: combinational decode feeding a
// two-entry (main + skid) ready/valid register stage, plus an illegal-opcode counter.
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_type,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt,
    input  logic             cnt_clr
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    localparam logic [2:0] T_NONE = 3'd0;
    localparam logic [2:0] T_I    = 3'd1;
    localparam logic [2:0] T_S    = 3'd2;
    localparam logic [2:0] T_B    = 3'd3;
    localparam logic [2:0] T_U    = 3'd4;
    localparam logic [2:0] T_J    = 3'd5;
    localparam logic [2:0] T_ILL  = 3'd7;
    localparam bit         RV64   = (XLEN == 64);

    state_t state;
    state_t state_next;

    logic [6:0]      opcode;
    logic [XLEN-1:0] imm_i;
    logic [XLEN-1:0] imm_s;
    logic [XLEN-1:0] imm_b;
    logic [XLEN-1:0] imm_u;
    logic [XLEN-1:0] imm_j;
    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_type;

    logic [XLEN-1:0]  main_imm;
    logic [2:0]       main_type;
    logic [TAG_W-1:0] main_tag;
    logic [XLEN-1:0]  skid_imm;
    logic [2:0]       skid_type;
    logic [TAG_W-1:0] skid_tag;
    logic [CNT_W-1:0] cnt;

    logic in_fire;
    logic out_fire;
    logic load_main;
    logic main_from_skid;
    logic load_skid;

    assign opcode = in_instr[6:0];

    // Each format is assembled as a signed field, then widened so bit 31 fills up to XLEN.
    assign imm_i = XLEN'($signed(in_instr[31:20]));
    assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
    assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25],
                                  in_instr[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({in_instr[31:12], 12'h000}));
    assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20],
                                  in_instr[30:21], 1'b0}));

    always_comb begin
        dec_imm  = '0;
        dec_type = T_ILL;
        case (opcode)
            7'b0000011, 7'b0010011, 7'b1100111, 7'b1110011: begin
                dec_imm  = imm_i;
                dec_type = T_I;
            end
            7'b0011011: begin
                if (RV64) begin
                    dec_imm  = imm_i;
                    dec_type = T_I;
                end
            end
            7'b0100011: begin
                dec_imm  = imm_s;
                dec_type = T_S;
            end
            7'b1100011: begin
                dec_imm  = imm_b;
                dec_type = T_B;
            end
            7'b0110111, 7'b0010111: begin
                dec_imm  = imm_u;
                dec_type = T_U;
            end
            7'b1101111: begin
                dec_imm  = imm_j;
                dec_type = T_J;
            end
            7'b0110011: dec_type = T_NONE;
            7'b0111011: begin
                if (RV64) dec_type = T_NONE;
            end
            default: ;
        endcase
    end

    // valid/ready: a beat moves on any edge where valid & ready are both high; once
    // out_valid rises, out_imm/out_type/out_tag stay put until out_ready takes them.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= EMPTY;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        load_main      = 1'b0;
        main_from_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            EMPTY: begin
                if (in_fire) begin
                    state_next = ONE;
                    load_main  = 1'b1;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    load_main = 1'b1;
                end else if (out_fire) begin
                    state_next = EMPTY;
                end else if (in_fire) begin
                    state_next = TWO;
                    load_skid  = 1'b1;
                end
            end
            TWO: begin
                if (out_fire) begin
                    state_next     = ONE;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_imm  <= '0;
            main_type <= T_NONE;
            main_tag  <= '0;
            skid_imm  <= '0;
            skid_type <= T_NONE;
            skid_tag  <= '0;
        end else begin
            if (load_main) begin
                main_imm  <= main_from_skid ? skid_imm  : dec_imm;
                main_type <= main_from_skid ? skid_type : dec_type;
                main_tag  <= main_from_skid ? skid_tag  : in_tag;
            end
            if (load_skid) begin
                skid_imm  <= dec_imm;
                skid_type <= dec_type;
                skid_tag  <= in_tag;
            end
        end
    end

    // Clear beats a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst || cnt_clr) begin
            cnt <= '0;
        end else if (in_fire && dec_type == T_ILL && cnt != {CNT_W{1'b1}}) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign out_imm     = main_imm;
    assign out_type    = main_type;
    assign out_tag     = main_tag;
    assign illegal_cnt = cnt;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: an RV32 (CNT_W=2) and an RV64 instance share one input stream;
// a scoreboard per instance checks every output beat in order.
module tb_imm_gen_pipe;
    localparam int W = 99;  // {tag[31:0], type[2:0], imm[63:0]}

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic        cnt_clr;
    logic [31:0] in_instr;
    logic [31:0] in_tag;

    logic        in_ready32, in_ready64, out_valid32, out_valid64;
    logic [31:0] out_imm32;
    logic [63:0] out_imm64;
    logic [2:0]  out_type32, out_type64;
    logic [31:0] out_tag32, out_tag64;
    logic [1:0]  cnt32;
    logic [15:0] cnt64;

    int checks = 0;
    int passes = 0;
    logic [W-1:0] exp32_q[$];
    logic [W-1:0] exp64_q[$];

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(32), .CNT_W(2)) dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid32),
        .out_ready(out_ready), .out_imm(out_imm32), .out_type(out_type32),
        .out_tag(out_tag32), .illegal_cnt(cnt32), .cnt_clr(cnt_clr)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(32), .CNT_W(16)) dut64 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready64),
        .in_instr(in_instr), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_type(out_type64),
        .out_tag(out_tag64), .illegal_cnt(cnt64), .cnt_clr(cnt_clr)
    );

    function automatic logic [66:0] model(input logic [31:0] i, input bit rv64);
        logic [63:0] imm;
        logic [2:0]  t;
        logic        sg;
        sg  = i[31];
        imm = '0;
        t   = 3'd7;
        case (i[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: begin t = 3'd1; imm = {{52{sg}}, i[31:20]}; end
            7'h1B: if (rv64) begin t = 3'd1; imm = {{52{sg}}, i[31:20]}; end
            7'h23: begin t = 3'd2; imm = {{52{sg}}, i[31:25], i[11:7]}; end
            7'h63: begin t = 3'd3; imm = {{51{sg}}, i[31], i[7], i[30:25], i[11:8], 1'b0}; end
            7'h37, 7'h17: begin t = 3'd4; imm = {{32{sg}}, i[31:12], 12'h000}; end
            7'h6F: begin t = 3'd5; imm = {{43{sg}}, i[31], i[19:12], i[20], i[30:21], 1'b0}; end
            7'h33: t = 3'd0;
            7'h3B: if (rv64) t = 3'd0;
            default: ;
        endcase
        return {t, imm};
    endfunction

    task automatic push_exp(input logic [31:0] instr, input logic [31:0] tag);
        exp32_q.push_back({tag, model(instr, 1'b0)});
        exp64_q.push_back({tag, model(instr, 1'b1)});
    endtask

    // Scoreboard: a beat is taken at the next posedge when valid & ready hold at the negedge.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst && out_valid32 && out_ready) begin
            checks++;
            if (exp32_q.size() == 0) begin
                $display("FAIL sb32_unexpected got tag=%h required no beat", out_tag32);
            end else begin
                e = exp32_q.pop_front();
                if ({out_tag32, out_type32, out_imm32} !== {e[98:67], e[66:64], e[31:0]})
                    $display("FAIL sb32 got tag=%h type=%0d imm=%h required tag=%h type=%0d imm=%h",
                             out_tag32, out_type32, out_imm32, e[98:67], e[66:64], e[31:0]);
                else passes++;
            end
        end
        if (!rst && out_valid64 && out_ready) begin
            checks++;
            if (exp64_q.size() == 0) begin
                $display("FAIL sb64_unexpected got tag=%h required no beat", out_tag64);
            end else begin
                e = exp64_q.pop_front();
                if ({out_tag64, out_type64, out_imm64} !== e)
                    $display("FAIL sb64 got tag=%h type=%0d imm=%h required tag=%h type=%0d imm=%h",
                             out_tag64, out_type64, out_imm64, e[98:67], e[66:64], e[63:0]);
                else passes++;
            end
        end
    end

    // Called just after a posedge; returns just after the posedge that accepted the beat.
    task automatic send(input logic [31:0] instr, input logic [31:0] tag);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
        @(negedge clk);
        while (!in_ready32 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (in_ready32 !== 1'b1) $display("FAIL send_timeout tag=%h in_ready=%b required 1", tag, in_ready32);
        else begin
            passes++;
            push_exp(instr, tag);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp32_q.size() != 0 || exp64_q.size() != 0) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp32_q.size() != 0 || exp64_q.size() != 0)
            $display("FAIL drain got pending=%0d/%0d required 0/0", exp32_q.size(), exp64_q.size());
        else passes++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F; in_tag = 32'hDEAD;
        out_ready = 1'b0; cnt_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        checks++;
        if ({out_valid32, in_ready32, out_imm32, out_type32, out_tag32, cnt32} !==
            {1'b0, 1'b1, 32'h0, 3'h0, 32'h0, 2'h0})
            $display("FAIL reset32 got v=%b rdy=%b imm=%h type=%0d tag=%h cnt=%0d required 0 1 0 0 0 0",
                     out_valid32, in_ready32, out_imm32, out_type32, out_tag32, cnt32);
        else passes++;
        checks++;
        if ({out_valid64, in_ready64, out_imm64, out_type64, out_tag64, cnt64} !==
            {1'b0, 1'b1, 64'h0, 3'h0, 32'h0, 16'h0})
            $display("FAIL reset64 got v=%b rdy=%b imm=%h type=%0d tag=%h cnt=%0d required 0 1 0 0 0 0",
                     out_valid64, in_ready64, out_imm64, out_type64, out_tag64, cnt64);
        else passes++;
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        send(32'hFFF00093, 32'h100);
        checks++;
        if (out_valid32 !== 1'b1 || out_imm32 !== 32'hFFFFFFFF || out_type32 !== 3'd1)
            $display("FAIL addi got v=%b imm=%h type=%0d required 1 ffffffff 1",
                     out_valid32, out_imm32, out_type32);
        else passes++;
        drain();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w[4]  = '{32'hFE112E23, 32'h00000463, 32'h123452B7, 32'hFFDFF06F};
        logic [31:0] ei[4] = '{32'hFFFFFFFC, 32'h00000008, 32'h12345000, 32'hFFFFFFFC};
        logic [2:0]  et[4] = '{3'd2, 3'd3, 3'd4, 3'd5};
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) begin
                in_valid = 1'b1;
                in_instr = w[i];
                in_tag   = 32'h200 + 32'(i * 4);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (out_valid32 !== 1'b1 || out_imm32 !== ei[i-1] || out_type32 !== et[i-1])
                    $display("FAIL b2b_%0d got v=%b imm=%h type=%0d required 1 %h %0d",
                             i - 1, out_valid32, out_imm32, out_type32, ei[i-1], et[i-1]);
                else passes++;
            end
            if (i < 4) begin
                checks++;
                if (in_ready32 !== 1'b1) $display("FAIL b2b_ready_%0d got %b required 1", i, in_ready32);
                else begin
                    passes++;
                    push_exp(w[i], in_tag);
                end
            end
            @(posedge clk);
            #1;
        end
        drain();
    endtask

    task automatic test_stall();
        logic [66:0] hold;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) send(32'h00A00513 + 32'(i << 20), 32'(i * 4));
            end
            begin
                @(negedge clk);
                @(negedge clk);
                hold = {out_imm32, out_type32, out_tag32};
                checks++;
                if (out_valid32 !== 1'b1 || out_tag32 !== 32'h0)
                    $display("FAIL stall_first got v=%b tag=%h required 1 0", out_valid32, out_tag32);
                else passes++;
                @(negedge clk);
                checks++;
                if (in_ready32 !== 1'b0) $display("FAIL stall_full got in_ready=%b required 0", in_ready32);
                else passes++;
                checks++;
                if ({out_imm32, out_type32, out_tag32} !== hold || out_valid32 !== 1'b1)
                    $display("FAIL stall_hold1 got %h v=%b required %h v=1",
                             {out_imm32, out_type32, out_tag32}, out_valid32, hold);
                else passes++;
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                @(negedge clk);
                checks++;
                if ({out_imm32, out_type32, out_tag32} !== hold || out_valid32 !== 1'b1)
                    $display("FAIL stall_hold2 got %h v=%b required %h v=1",
                             {out_imm32, out_type32, out_tag32}, out_valid32, hold);
                else passes++;
            end
        join
        drain();
    endtask

    task automatic test_counter();
        logic [1:0] exp_c32;
        out_ready = 1'b1;
        cnt_clr   = 1'b1;
        @(posedge clk);
        #1;
        cnt_clr = 1'b0;
        exp_c32 = 2'd0;
        for (int i = 0; i < 5; i++) begin
            send(32'h0000007F, 32'h300 + 32'(i * 4));
            exp_c32 = (exp_c32 == 2'd3) ? 2'd3 : exp_c32 + 2'd1;
            checks++;
            if (cnt32 !== exp_c32 || cnt64 !== 16'(i + 1))
                $display("FAIL cnt_%0d got %0d/%0d required %0d/%0d", i, cnt32, cnt64, exp_c32, i + 1);
            else passes++;
            checks++;
            if (out_type32 !== 3'd7 || out_imm32 !== 32'h0 || out_type64 !== 3'd7 || out_imm64 !== 64'h0)
                $display("FAIL illegal_%0d got type=%0d/%0d imm=%h/%h required 7/7 0/0",
                         i, out_type32, out_type64, out_imm32, out_imm64);
            else passes++;
        end
        cnt_clr = 1'b1;
        send(32'h0000007F, 32'h314);
        cnt_clr = 1'b0;
        checks++;
        if (cnt32 !== 2'd0 || cnt64 !== 16'd0)
            $display("FAIL cnt_clr_wins got %0d/%0d required 0/0", cnt32, cnt64);
        else passes++;
        drain();
    endtask

    task automatic test_rv64();
        out_ready = 1'b1;
        send(32'hFFF00093, 32'h400);
        checks++;
        if (out_imm64 !== 64'hFFFFFFFFFFFFFFFF || out_type64 !== 3'd1)
            $display("FAIL rv64_addi got imm=%h type=%0d required ffffffffffffffff 1", out_imm64, out_type64);
        else passes++;
        send(32'h800002B7, 32'h404);
        checks++;
        if (out_imm64 !== 64'hFFFFFFFF80000000 || out_type64 !== 3'd4)
            $display("FAIL rv64_lui got imm=%h type=%0d required ffffffff80000000 4", out_imm64, out_type64);
        else passes++;
        send(32'h0010009B, 32'h408);
        checks++;
        if (out_imm64 !== 64'h1 || out_type64 !== 3'd1 || out_type32 !== 3'd7 || out_imm32 !== 32'h0)
            $display("FAIL addiw got imm64=%h type64=%0d type32=%0d imm32=%h required 1 1 7 0",
                     out_imm64, out_type64, out_type32, out_imm32);
        else passes++;
        drain();
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        send(32'h0000007F, 32'h500);
        send(32'h0000007F, 32'h504);
        checks++;
        if (in_ready32 !== 1'b0) $display("FAIL mid_two got in_ready=%b required 0", in_ready32);
        else passes++;
        rst = 1'b1; in_valid = 1'b1; in_instr = 32'h0000007F;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0;
        exp32_q.delete();
        exp64_q.delete();
        checks++;
        if (out_valid32 !== 1'b0 || out_valid64 !== 1'b0 || in_ready32 !== 1'b1 ||
            cnt32 !== 2'd0 || cnt64 !== 16'd0)
            $display("FAIL mid_reset got v=%b/%b rdy=%b cnt=%0d/%0d required 0/0 1 0/0",
                     out_valid32, out_valid64, in_ready32, cnt32, cnt64);
        else passes++;
        out_ready = 1'b1;
        send(32'hFFF00093, 32'h600);
        checks++;
        if (out_valid32 !== 1'b1 || out_tag32 !== 32'h600 || out_imm32 !== 32'hFFFFFFFF)
            $display("FAIL mid_restart got v=%b tag=%h imm=%h required 1 600 ffffffff",
                     out_valid32, out_tag32, out_imm32);
        else passes++;
        drain();
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_stall();
        test_counter();
        test_rv64();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout required completion");
        $fatal(1, "watchdog");
    end

endmodule
